// File: rtl/ula_pkg.sv
// Shared definitions for the multi-byte ALU sequencer: op codes and FSM state encoding.
package ula_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_EQ  = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_MUX = 3'b110;
    localparam logic [2:0] OP_ILL = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/ula.sv
// 8-bit combinational ALU. EQ reports equality in s[0]; MUX returns bit a[b[2:0]] in s[0].
module ula
    import ula_pkg::*;
(
    input  logic [2:0] op,
    output logic [7:0] s,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic       cout
);

    always_comb begin
        s    = 8'h00;
        cout = 1'b0;
        case (op)
            OP_AND: s = a & b;
            OP_OR:  s = a | b;
            OP_XOR: s = a ^ b;
            OP_NOT: s = ~a;
            OP_EQ:  s = {7'b0, (a == b)};
            OP_ADD: {cout, s} = {1'b0, a} + {1'b0, b} + {8'b0, cin};
            OP_MUX: s = {7'b0, a[b[2:0]]};
            default: begin
                s    = 8'h00;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ula_seq.sv
// Multi-byte operation sequencer: feeds one byte per clock through the 8-bit ALU,
// low byte first, chaining carry for ADD and AND-reducing byte matches for EQ.
module ula_seq
    import ula_pkg::*;
#(
    parameter int NBYTES = 4,
    parameter int SELW   = $clog2(8*NBYTES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_op,
    input  logic [8*NBYTES-1:0] req_a,
    input  logic [8*NBYTES-1:0] req_b,
    input  logic                req_cin,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [8*NBYTES-1:0] rsp_s,
    output logic                rsp_cout,
    output logic                rsp_err,
    output logic                busy
);

    localparam int W    = 8*NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    state_t            state_reg, state_next;
    logic [2:0]        op_reg;
    logic [W-1:0]      a_reg, b_reg;
    logic [W-1:0]      result_reg, result_next;
    logic [IDXW-1:0]   idx_reg;
    logic              carry_reg;
    logic              eq_acc_reg;
    logic              rsp_valid_reg;
    logic [W-1:0]      rsp_s_reg;
    logic              rsp_cout_reg;
    logic              rsp_err_reg;

    logic [7:0]        a_bytes [NBYTES];
    logic [7:0]        b_bytes [NBYTES];
    logic [IDXW-1:0]   mux_idx;
    logic              mux_oob;
    logic [IDXW-1:0]   byte_idx;
    logic [7:0]        alu_a, alu_b, alu_s;
    logic              alu_cout;
    logic              exec_last;
    logic [W-1:0]      final_s;

    // Byte views of the captured operands, and the result with the current byte merged in.
    for (genvar gi = 0; gi < NBYTES; gi++) begin : g_bytes
        assign a_bytes[gi] = a_reg[gi*8 +: 8];
        assign b_bytes[gi] = b_reg[gi*8 +: 8];
        assign result_next[gi*8 +: 8] = (idx_reg == IDXW'(gi)) ? alu_s : result_reg[gi*8 +: 8];
    end

    // MUX: upper index bits pick the byte, the low three pick the bit inside it.
    if (NBYTES > 1) begin : g_mux_sel
        assign mux_idx = b_reg[SELW-1:3];
        assign mux_oob = (32'(mux_idx) >= NBYTES);
    end else begin : g_mux_sel_single
        assign mux_idx = '0;
        assign mux_oob = 1'b0;
    end

    always_comb begin
        byte_idx = idx_reg;
        if (op_reg == OP_MUX) begin
            byte_idx = mux_oob ? '0 : mux_idx;
        end
    end

    assign alu_a = a_bytes[byte_idx];
    assign alu_b = (op_reg == OP_MUX) ? {5'b0, b_reg[2:0]} : b_bytes[byte_idx];

    ula u_ula (
        .op   (op_reg),
        .s    (alu_s),
        .a    (alu_a),
        .b    (alu_b),
        .cin  (carry_reg),
        .cout (alu_cout)
    );

    assign exec_last = (op_reg == OP_MUX) || (idx_reg == IDXW'(NBYTES-1));

    always_comb begin
        final_s = result_next;
        case (op_reg)
            OP_EQ:   final_s = W'(eq_acc_reg & alu_s[0]);
            OP_MUX:  final_s = W'(alu_s[0] & ~mux_oob);
            default: final_s = result_next;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    state_next = (req_op == OP_ILL) ? RESP : EXEC;
                end
            end
            EXEC: begin
                if (exec_last) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg        <= OP_AND;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            eq_acc_reg    <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_s_reg     <= '0;
            rsp_cout_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        op_reg     <= req_op;
                        a_reg      <= req_a;
                        b_reg      <= req_b;
                        carry_reg  <= (req_op == OP_ADD) ? req_cin : 1'b0;
                        idx_reg    <= '0;
                        eq_acc_reg <= 1'b1;
                        result_reg <= '0;
                        if (req_op == OP_ILL) begin
                            // Illegal op skips execution and answers straight away.
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b1;
                            rsp_s_reg     <= '0;
                            rsp_cout_reg  <= 1'b0;
                        end else begin
                            rsp_err_reg   <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    result_reg <= result_next;
                    idx_reg    <= idx_reg + 1'b1;
                    if (op_reg == OP_ADD) begin
                        carry_reg <= alu_cout;
                    end
                    if (op_reg == OP_EQ) begin
                        eq_acc_reg <= eq_acc_reg & alu_s[0];
                    end
                    if (exec_last) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_s_reg     <= final_s;
                        rsp_cout_reg  <= (op_reg == OP_ADD) ? alu_cout : 1'b0;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (state_reg == IDLE);
    assign busy      = (state_reg == EXEC) || (state_reg == RESP);
    assign rsp_valid = rsp_valid_reg;
    assign rsp_s     = rsp_s_reg;
    assign rsp_cout  = rsp_cout_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_ula_seq.sv
// Scoreboard bench for ula_seq: directed and random requests, a wide-arithmetic reference
// model, and a monitor that checks latency, hold stability and response contents.
module tb_ula_seq;
    import ula_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8*NBYTES;
    localparam int SELW   = $clog2(W);

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [2:0]   req_op = 3'b000;
    logic [W-1:0] req_a = '0;
    logic [W-1:0] req_b = '0;
    logic         req_cin = 1'b0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_s;
    logic         rsp_cout;
    logic         rsp_err;
    logic         busy;

    ula_seq #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_s     (rsp_s),
        .rsp_cout  (rsp_cout),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [W-1:0] s;
        logic         cout;
        logic         err;
        int           tv;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rsp_mode = 0;   // 0 random, 1 hold low, 2 hold high

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cin);
        exp_t e;
        logic [W:0] sum;
        e.s = '0; e.cout = 1'b0; e.err = 1'b0; e.tv = 0;
        case (op)
            OP_AND: e.s = a & b;
            OP_OR:  e.s = a | b;
            OP_XOR: e.s = a ^ b;
            OP_NOT: e.s = ~a;
            OP_EQ:  e.s = (a == b) ? W'(1) : W'(0);
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                e.s = sum[W-1:0];
                e.cout = sum[W];
            end
            OP_MUX: e.s = W'(a[b[SELW-1:0]]);
            default: e.err = 1'b1;
        endcase
        return e;
    endfunction

    function automatic int latency(input logic [2:0] op);
        if (op == OP_ILL) return 1;
        if (op == OP_MUX) return 2;
        return NBYTES + 1;
    endfunction

    always @(posedge clk) begin
        #2;
        case (rsp_mode)
            0:       rsp_ready = 1'($urandom_range(0, 1));
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'b1;
        endcase
    end

    // Monitor: first rise checks latency, waiting cycles check stability, handshake pops.
    logic         in_rsp = 1'b0;
    logic [W-1:0] held_s = '0;
    exp_t         mon_e;
    always @(negedge clk) begin
        if (!rst_n) begin
            in_rsp = 1'b0;
        end else if (rsp_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got rsp_s=%h with no request outstanding (cycle %0d)", rsp_s, cyc);
            end else begin
                if (!in_rsp) begin
                    chk("latency", W'(cyc), W'(sb[0].tv));
                    in_rsp = 1'b1;
                    held_s = rsp_s;
                end else begin
                    chk("hold_stable", rsp_s, held_s);
                end
                if (rsp_ready) begin
                    mon_e = sb.pop_front();
                    chk("rsp_s", rsp_s, mon_e.s);
                    chk("rsp_cout", W'(rsp_cout), W'(mon_e.cout));
                    chk("rsp_err", W'(rsp_err), W'(mon_e.err));
                    $display("rsp: s=%h cout=%0b err=%0b at cycle %0d", rsp_s, rsp_cout, rsp_err, cyc);
                    in_rsp = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input bit push);
        int   n;
        exp_t e;
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_cin = cin;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got req_ready=0 expected 1 within 200 cycles");
        end else begin
            $display("req: op=%0d a=%h b=%h cin=%0b accepted at cycle %0d", op, a, b, cin, cyc);
            if (push) begin
                e = model(op, a, b, cin);
                e.tv = cyc + latency(op);
                sb.push_back(e);
            end
        end
        @(posedge clk); #1;
        // Scramble the request bus after acceptance; it must have no effect.
        req_valid = 1'b0;
        req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_cin = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses expected 0", sb.size());
        end
    endtask

    initial begin
        int n;
        logic [2:0]   op;
        logic [W-1:0] a, b;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", W'(rsp_valid), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        chk("rst_rsp_s", rsp_s, W'(0));
        chk("rst_rsp_cout", W'(rsp_cout), W'(0));
        chk("rst_rsp_err", W'(rsp_err), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", W'(req_ready), W'(1));

        send(OP_ADD, 32'h000000FF, 32'h00000001, 1'b0, 1'b1);
        send(OP_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b1);
        send(OP_EQ,  32'h12345678, 32'h12345678, 1'b1, 1'b1);
        send(OP_EQ,  32'h12345678, 32'h12345679, 1'b0, 1'b1);
        send(OP_EQ,  32'h02345678, 32'h12345678, 1'b0, 1'b1);
        send(OP_MUX, 32'h80000000, 32'd31, 1'b0, 1'b1);
        send(OP_MUX, 32'h80000000, 32'd30, 1'b1, 1'b1);
        send(OP_MUX, 32'h00000400, 32'd10, 1'b0, 1'b1);
        send(OP_NOT, 32'h00FF00FF, 32'h5A5A5A5A, 1'b1, 1'b1);
        send(OP_AND, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b1, 1'b1);
        send(OP_XOR, 32'hF0F0F0F0, 32'h3C3C3C3C, 1'b0, 1'b1);
        send(OP_OR,  32'h0F000001, 32'h00F00010, 1'b1, 1'b1);
        send(OP_ILL, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b1);
        drain();

        // Backpressure: response held while a second request waits and is refused.
        rsp_mode = 1;
        send(OP_XOR, 32'hA5A5A5A5, 32'h0F0F0F0F, 1'b0, 1'b1);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("hold_rsp_arrives", W'(rsp_valid), W'(1));
        @(posedge clk); #1;
        req_valid = 1'b1; req_op = OP_ADD; req_a = 32'h11111111; req_b = 32'h22222222;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_req_ready", W'(req_ready), W'(0));
            chk("hold_busy", W'(busy), W'(1));
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        rsp_mode = 2;
        @(negedge clk);
        @(negedge clk);
        chk("release_idle", W'(req_ready), W'(1));
        chk("release_valid", W'(rsp_valid), W'(0));
        rsp_mode = 0;
        drain();

        // Reset during the second EXEC cycle of an ADD aborts without a response.
        send(OP_ADD, 32'h01020304, 32'h10203040, 1'b1, 1'b0);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", W'(rsp_valid), W'(0));
        chk("abort_busy", W'(busy), W'(0));
        chk("abort_rsp_s", rsp_s, W'(0));
        chk("abort_rsp_cout", W'(rsp_cout), W'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", W'(req_ready), W'(1));
        send(OP_ADD, 32'd5, 32'd7, 1'b0, 1'b1);
        drain();

        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            if (op == OP_EQ && $urandom_range(0, 1) == 1) b = a;
            if (op == OP_ADD && $urandom_range(0, 3) == 0) a = ~b;
            send(op, a, b, 1'($urandom), 1'b1);
        end
        drain();
        rsp_mode = 2;
        repeat (3) @(posedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected completion within 500000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Multi-byte operation sequencer built around the existing 8-bit combinational ALU `ula`.
- Accepts one wide request (8*NBYTES-bit operands) through a valid/ready handshake.
- Issues one ALU operation per clock, low byte first; chains carry for ADD and reduces per-byte results for EQ.
- Returns the wide result through a second valid/ready handshake. Sits between the instruction/control logic and the ALU, so only this block drives the ALU.

Parameters:
- NBYTES, 4, operand width in bytes (W = 8*NBYTES); legal range 1..16.
- SELW, $clog2(8*NBYTES), width of the bit-select index for the MUX op.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_op  in  3  000 AND, 001 OR, 010 XOR, 011 NOT(a), 100 EQ, 101 ADD, 110 MUX, 111 illegal.
- req_a  in  W  operand A.
- req_b  in  W  operand B; for MUX, b[SELW-1:0] is the bit index into A.
- req_cin  in  1  carry-in; used by ADD only.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_s  out  W  result.
- rsp_cout  out  1  carry-out; ADD only, 0 otherwise.
- rsp_err  out  1  request had an illegal op.
- busy  out  1  high in EXEC or RESP.

Behaviour:
- Reset values (async, rst_n low): state IDLE; rsp_valid 0; rsp_s 0; rsp_cout 0; rsp_err 0; busy 0; internal index and carry 0.
- req_ready = (state==IDLE). It is therefore 1 immediately after reset release.
- State machine: IDLE, EXEC, RESP.
- IDLE, on req_valid (accept cycle T):
  - Capture op, a, b.
  - carry <= (op==ADD) ? req_cin : 0.
  - idx <= 0, eq_acc <= 1, result <= 0.
  - op 111: go to RESP with rsp_err=1, rsp_s=0, rsp_cout=0.
  - Any other op: go to EXEC.
- EXEC, one byte per cycle:
  - ALU inputs: op; a byte[idx]; b byte[idx]; cin = carry.
  - AND/OR/XOR/NOT: result byte[idx] <= ALU s.
  - ADD: result byte[idx] <= ALU s; carry <= ALU cout.
  - EQ: the ALU returns s[0]=1 for an equal byte, other bits 0. eq_acc <= eq_acc & s[0]. Result is eq_acc zero-extended to W.
  - MUX:
    - Byte select = b[SELW-1:3]. ALU a = that byte of A. ALU b = {5'b0, b[2:0]}.
    - Exactly one EXEC cycle. rsp_s = selected bit zero-extended.
    - For NBYTES=1, byte select is 0.
  - Leave EXEC when idx==NBYTES-1 (or after the single MUX cycle), going to RESP.
  - On exit: rsp_valid <= 1. rsp_cout <= final carry for ADD, else 0.
- Latency (accept at T):
  - NBYTES-cycle ops: rsp_valid first high at T+NBYTES+1.
  - MUX: T+2.
  - Illegal op: T+1.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid <= 0, return to IDLE.
  - Next request accepted no earlier than the cycle after the handshake.
  - No overlap of requests; throughput is one per NBYTES+2 cycles minimum.
- Boundary conditions:
  - ADD top byte overflow: rsp_cout=1, rsp_s wraps modulo 2^W.
  - cin is ignored for every op except ADD.
  - NOT ignores B.
  - req_valid while busy: ignored; req_ready=0, no capture.
  - req_* inputs may change after the accept cycle without effect.
  - Reset mid-EXEC or mid-RESP: immediate abort, outputs return to reset values, no response is produced.

Decomposition:
- Package ula_pkg:
  - Op localparams OP_AND..OP_MUX and OP_ILL=3'b111.
  - FSM state encoding (IDLE=2'd0, EXEC=2'd1, RESP=2'd2).
- Reuse the existing `ula` as the only sub-module, instantiated once with port order (op, s, a, b, cin, cout).
- Byte slicing, carry register, eq reduction and FSM stay in ula_seq.

Test Plan:
- ADD chain, NBYTES=4:
  - a=0x000000FF, b=0x00000001, cin=0 -> rsp_s=0x00000100, rsp_cout=0, rsp_valid at T+5.
  - a=0xFFFFFFFF, b=0x00000000, cin=1 -> rsp_s=0x00000000, rsp_cout=1.
- EQ:
  - a=b=0x12345678 -> rsp_s=0x00000001.
  - a=0x12345678, b=0x12345679 -> rsp_s=0x00000000.
  - a=0x02345678, b=0x12345678 (top-byte mismatch) -> rsp_s=0.
- MUX, a=0x80000000:
  - b=31 -> rsp_s=1, rsp_valid at T+2.
  - b=30 -> rsp_s=0.
  - a=0x00000400, b=10 -> rsp_s=1.
- Logic ops:
  - NOT a=0x00FF00FF -> 0xFF00FF00, rsp_cout=0, with cin=1 ignored.
  - AND 0xF0F0F0F0 & 0x3C3C3C3C -> 0x30303030.
  - XOR of the same operands -> 0xCCCCCCCC.
- Handshake and illegal op:
  - Hold rsp_ready=0 for 10 cycles with req_valid=1 -> rsp_s stable, req_ready=0, second request not captured. Release -> IDLE one cycle later.
  - op=111 -> rsp_err=1, rsp_s=0, rsp_valid at T+1.
- Reset abort:
  - Deassert rst_n during the 2nd EXEC cycle of an ADD -> rsp_valid, busy and rsp_s go to 0 asynchronously. After release, req_ready=1 and a fresh ADD 5+7 returns 12.
